mvp_matrix_fifo: RTL and testbench
==================================

// Module: mvp_matrix_fifo
// PURPOSE
//   Responder side of the MVP-matrix read handshake: queues complete 4x4 fixed-point MVP matrices,
//   loaded one word per cycle, and returns one whole matrix to the render-control FSM per
//   read_en request, with a one-cycle data-valid pulse. Sits between the host/matrix loader and the
//   frame render controller. Each matrix carries the model id it applies to.
// PARAMETERS
//   DATAWIDTH          24  signed word width of each matrix element (Q.13 fixed point, opaque here)
//   DEPTH              4   number of whole matrices stored; power of two, >=2
//   MODEL_INDEX_WIDTH  4   width of the model id tag stored with each matrix
// PORTS
//   clk              in   1                   system clock; all logic on posedge
//   reset            in   1                   synchronous, active-high reset
//   i_wr_data        in   DATAWIDTH (signed)  matrix element, row-major order m[0][0],m[0][1]..m[3][3]
//   i_wr_model_id    in   MODEL_INDEX_WIDTH   model tag; sampled on the 16th accepted word only
//   i_wr_valid       in   1                   write word valid; accepted when i_wr_valid & o_wr_ready
//   o_wr_ready       out  1                   high when a free matrix slot exists (count < DEPTH)
//   i_flush          in   1                   discard all stored and partially loaded matrices
//   i_read_en        in   1                   pop request: one matrix per cycle it is high
//   o_mvp_matrix     out  DATAWIDTH [4][4]    registered matrix of the last successful pop
//   o_model_id       out  MODEL_INDEX_WIDTH   registered tag of the last successful pop
//   o_mvp_dv         out  1                   one-cycle pulse: o_mvp_matrix/o_model_id valid
//   o_empty          out  1                   count == 0
//   o_full           out  1                   count == DEPTH
//   o_count          out  $clog2(DEPTH+1)     committed matrices stored
//   o_underflow      out  1                   one-cycle pulse: read_en while empty
// BEHAVIOUR
//   - Reset: pointers, word index, count = 0; o_mvp_matrix = all 0; o_model_id = 0; o_mvp_dv = 0;
//     o_underflow = 0; o_wr_ready = 1; o_empty = 1; o_full = 0. Reset mid-load discards the partial.
//   - Write FSM: LOAD (word index 0..15) writes element [idx>>2][idx&3] of slot wr_ptr.
//     Word 15 accepted -> store model id, COMMIT in same edge: wr_ptr+1 (wraps mod DEPTH),
//     count+1, idx back to 0. A matrix is never visible to the reader before commit.
//   - o_wr_ready = (count < DEPTH), combinational from count; a partial matrix in progress holds its
//     slot, so ready drops only at commit when count reaches DEPTH; words while !ready are ignored.
//   - Read: i_read_en & !empty -> next edge: o_mvp_matrix/o_model_id <= slot rd_ptr, o_mvp_dv <= 1,
//     rd_ptr+1 (wraps), count-1. Latency read_en -> dv = 1 cycle. Outputs hold until next pop.
//   - i_read_en & empty -> o_underflow pulses 1 cycle; no dv; outputs, pointers unchanged.
//   - i_read_en held high N cycles pops min(N, count) matrices back to back, dv high each pop.
//   - Simultaneous commit and pop: count unchanged, both pointers advance; when count==0 the
//     committing matrix is NOT returned this cycle (underflow pulses); it is poppable next cycle.
//   - Simultaneous commit and pop while full-minus-one etc.: count arithmetic = +commit -pop, never
//     exceeds DEPTH, never negative.
//   - i_flush: next edge pointers, idx, count = 0; pending pop/commit in that cycle are dropped;
//     o_mvp_dv and o_underflow forced 0; o_mvp_matrix/o_model_id keep last values. reset wins over flush.
// TESTING
//   1 Reset, load 16 words 1..16 tag 3, pulse read_en -> 1 cycle later dv=1, m[0][0]=1, m[3][3]=16,
//     m[1][2]=7, model_id=3, empty=1 after.
//   2 Load DEPTH=4 matrices -> full=1, wr_ready=0; 5th matrix words ignored; pop 4 -> tags in load
//     order, count 4->0, wr_ready back to 1 after first pop.
//   3 read_en when empty -> underflow pulse, dv=0, outputs hold previous matrix values.
//   4 Load 15 words, then flush, then load a fresh matrix of negative values (-1..-16) -> pop returns
//     only the fresh matrix, sign preserved, count=1 before pop.
//   5 With count=2, commit 16th word and pop in same cycle -> count stays 2, dv=1, FIFO order kept;
//     with count=0 same event -> underflow=1, next pop returns the new matrix.
//   6 Assert reset in mid-load and mid-pop -> all outputs to reset values next edge; wrap pointers
//     by loading/popping 10 matrices continuously, check order and tags.

Source files
------------

// File: rtl/mvp_matrix_fifo.sv
// mvp_matrix_fifo: queue of whole 4x4 MVP matrices for the render controller.
// Matrices arrive one element per cycle in row-major order. A matrix becomes visible to
// the reader only once its 16th word commits it. Each read_en pop returns a complete
// matrix and its model tag, one cycle later, with a single-cycle valid pulse.
module mvp_matrix_fifo #(
    parameter int DATAWIDTH         = 24,
    parameter int DEPTH             = 4,
    parameter int MODEL_INDEX_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic signed [DATAWIDTH-1:0]         i_wr_data,
    input  logic [MODEL_INDEX_WIDTH-1:0]        i_wr_model_id,
    input  logic                                i_wr_valid,
    output logic                                o_wr_ready,
    input  logic                                i_flush,
    input  logic                                i_read_en,
    output logic [3:0][3:0][DATAWIDTH-1:0]      o_mvp_matrix,
    output logic [MODEL_INDEX_WIDTH-1:0]        o_model_id,
    output logic                                o_mvp_dv,
    output logic                                o_empty,
    output logic                                o_full,
    output logic [$clog2(DEPTH+1)-1:0]          o_count,
    output logic                                o_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef logic [3:0][3:0][DATAWIDTH-1:0] matrix_t;

    // WR_IDLE: waiting for the first element of a matrix; WR_LOAD: a partial matrix is in progress.
    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_LOAD = 1'b1
    } wr_state_t;

    wr_state_t                    wr_state_q, wr_state_d;
    logic [3:0]                   idx_q, idx_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    matrix_t                      mvp_q, mvp_d;
    logic [MODEL_INDEX_WIDTH-1:0] model_id_q, model_id_d;
    logic                         dv_q, dv_d;
    logic                         underflow_q, underflow_d;

    matrix_t                      mat_mem [DEPTH];
    logic [MODEL_INDEX_WIDTH-1:0] tag_mem [DEPTH];

    logic wr_fire;
    logic commit;
    logic pop;
    logic underflow_req;

    // Handshake decode: the partial matrix owns slot wr_ptr, so space exists whenever count < DEPTH.
    always_comb begin
        wr_fire       = i_wr_valid && (count_q < DEPTH_C);
        commit        = wr_fire && (idx_q == 4'd15);
        pop           = i_read_en && (count_q != '0);
        underflow_req = i_read_en && (count_q == '0);
    end

    // Write FSM: walk the element index and commit the slot on the 16th accepted word.
    always_comb begin
        wr_state_d = wr_state_q;
        idx_d      = idx_q;
        wr_ptr_d   = wr_ptr_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_fire) begin
                    idx_d      = 4'd1;
                    wr_state_d = WR_LOAD;
                end
            end
            WR_LOAD: begin
                if (wr_fire) begin
                    idx_d = idx_q + 4'd1;
                    if (commit) begin
                        idx_d      = 4'd0;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        wr_state_d = WR_IDLE;
                    end
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
            end
        endcase
        if (i_flush) begin
            wr_state_d = WR_IDLE;
            idx_d      = 4'd0;
            wr_ptr_d   = '0;
        end
    end

    // Read side and occupancy: pop registers the head slot; count tracks +commit -pop.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mvp_d       = mvp_q;
        model_id_d  = model_id_q;
        dv_d        = 1'b0;
        underflow_d = underflow_req;
        if (pop) begin
            mvp_d      = mat_mem[rd_ptr_q];
            model_id_d = tag_mem[rd_ptr_q];
            dv_d       = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
        end
        case ({commit, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (i_flush) begin
            rd_ptr_d    = '0;
            count_d     = '0;
            mvp_d       = mvp_q;
            model_id_d  = model_id_q;
            dv_d        = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // Matrix storage: element and tag writes; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_fire && !i_flush) begin
            mat_mem[wr_ptr_q][idx_q[3:2]][idx_q[1:0]] <= i_wr_data;
            if (commit) begin
                tag_mem[wr_ptr_q] <= i_wr_model_id;
            end
        end
    end

    // State registers with synchronous reset, which also discards any partial matrix.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q  <= WR_IDLE;
            idx_q       <= 4'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mvp_q       <= '0;
            model_id_q  <= '0;
            dv_q        <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mvp_q       <= mvp_d;
            model_id_q  <= model_id_d;
            dv_q        <= dv_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_wr_ready   = (count_q < DEPTH_C);
    assign o_full       = (count_q == DEPTH_C);
    assign o_empty      = (count_q == '0);
    assign o_count      = count_q;
    assign o_mvp_matrix = mvp_q;
    assign o_model_id   = model_id_q;
    assign o_mvp_dv     = dv_q;
    assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_mvp_matrix_fifo.sv
// Directed bench for mvp_matrix_fifo: one task per scenario, inline comparisons.
module tb_mvp_matrix_fifo;

    logic                   clk;
    logic                   reset;
    logic [23:0]            i_wr_data;
    logic [3:0]             i_wr_model_id;
    logic                   i_wr_valid;
    logic                   o_wr_ready;
    logic                   i_flush;
    logic                   i_read_en;
    logic [3:0][3:0][23:0]  o_mvp_matrix;
    logic [3:0]             o_model_id;
    logic                   o_mvp_dv;
    logic                   o_empty;
    logic                   o_full;
    logic [2:0]             o_count;
    logic                   o_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    mvp_matrix_fifo #(
        .DATAWIDTH(24),
        .DEPTH(4),
        .MODEL_INDEX_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_wr_data(i_wr_data),
        .i_wr_model_id(i_wr_model_id),
        .i_wr_valid(i_wr_valid),
        .o_wr_ready(o_wr_ready),
        .i_flush(i_flush),
        .i_read_en(i_read_en),
        .o_mvp_matrix(o_mvp_matrix),
        .o_model_id(o_model_id),
        .o_mvp_dv(o_mvp_dv),
        .o_empty(o_empty),
        .o_full(o_full),
        .o_count(o_count),
        .o_underflow(o_underflow)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n consecutive words, element i carrying base + step*i.
    task automatic load_words(input int base, input int step, input int start, input int n,
                              input logic [3:0] tag);
        for (int i = start; i < start + n; i++) begin
            i_wr_valid    = 1'b1;
            i_wr_data     = 24'(base + step * i);
            i_wr_model_id = tag;
            tick();
        end
        i_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", o_count); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", o_empty); end
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", o_full); end
        n_checks++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", o_wr_ready); end
        n_checks++; if (o_mvp_dv !== 1'b0 || o_underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got dv=%b uf=%b expected 0 0", o_mvp_dv, o_underflow); end
        n_checks++; if (o_mvp_matrix !== '0 || o_model_id !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_outputs: got id=%0d m00=%0d expected 0 0", o_model_id, o_mvp_matrix[0][0]); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        load_words(1, 1, 0, 16, 4'd3);
        n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("[TB] FAIL single_count: got %0d expected 1", o_count); end
        n_checks++; if (o_mvp_dv !== 1'b0) begin n_fail++; $display("[TB] FAIL single_dv_early: got %b expected 0", o_mvp_dv); end
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        n_checks++; if (o_mvp_dv !== 1'b1) begin n_fail++; $display("[TB] FAIL single_dv: got %b expected 1", o_mvp_dv); end
        n_checks++; if (o_mvp_matrix[0][0] !== 24'd1) begin n_fail++; $display("[TB] FAIL single_m00: got %0d expected 1", o_mvp_matrix[0][0]); end
        n_checks++; if (o_mvp_matrix[3][3] !== 24'd16) begin n_fail++; $display("[TB] FAIL single_m33: got %0d expected 16", o_mvp_matrix[3][3]); end
        n_checks++; if (o_mvp_matrix[1][2] !== 24'd7) begin n_fail++; $display("[TB] FAIL single_m12: got %0d expected 7", o_mvp_matrix[1][2]); end
        n_checks++; if (o_model_id !== 4'd3) begin n_fail++; $display("[TB] FAIL single_tag: got %0d expected 3", o_model_id); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL single_empty: got %b expected 1", o_empty); end
        tick();
        n_checks++; if (o_mvp_dv !== 1'b0) begin n_fail++; $display("[TB] FAIL single_dv_pulse: got %b expected 0", o_mvp_dv); end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 4; k++) begin
            load_words(100 * k, 1, 0, 16, 4'(k));
        end
        n_checks++; if (o_full !== 1'b1 || o_wr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_full: got full=%b ready=%b expected 1 0", o_full, o_wr_ready); end
        load_words(900, 1, 0, 16, 4'd9);
        n_checks++; if (o_count !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_ignored: got %0d expected 4", o_count); end
        i_read_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (o_mvp_dv !== 1'b1 || o_model_id !== 4'(k)) begin n_fail++; $display("[TB] FAIL fill_pop_tag: got dv=%b id=%0d expected 1 %0d", o_mvp_dv, o_model_id, k); end
            n_checks++; if (o_mvp_matrix[0][0] !== 24'(100 * k)) begin n_fail++; $display("[TB] FAIL fill_pop_data: got %0d expected %0d", o_mvp_matrix[0][0], 100 * k); end
            n_checks++; if (o_count !== 3'(4 - k)) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected %0d", o_count, 4 - k); end
            if (k == 1) begin
                n_checks++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_ready_back: got %b expected 1", o_wr_ready); end
            end
        end
        i_read_en = 1'b0;
        tick();
    endtask

    task automatic test_underflow();
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        n_checks++; if (o_underflow !== 1'b1 || o_mvp_dv !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_pulse: got uf=%b dv=%b expected 1 0", o_underflow, o_mvp_dv); end
        n_checks++; if (o_model_id !== 4'd4 || o_mvp_matrix[0][0] !== 24'd400) begin n_fail++; $display("[TB] FAIL uf_hold: got id=%0d m00=%0d expected 4 400", o_model_id, o_mvp_matrix[0][0]); end
        tick();
        n_checks++; if (o_underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_one_cycle: got %b expected 0", o_underflow); end
    endtask

    task automatic test_flush();
        logic signed [23:0] e;
        load_words(50, 1, 0, 15, 4'd2);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_checks++; if (o_count !== 3'd0 || o_model_id !== 4'd4) begin n_fail++; $display("[TB] FAIL flush_state: got count=%0d id=%0d expected 0 4", o_count, o_model_id); end
        load_words(-1, -1, 0, 16, 4'd5);
        n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("[TB] FAIL flush_count: got %0d expected 1", o_count); end
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        n_checks++; if (o_mvp_dv !== 1'b1 || o_model_id !== 4'd5) begin n_fail++; $display("[TB] FAIL flush_pop: got dv=%b id=%0d expected 1 5", o_mvp_dv, o_model_id); end
        e = o_mvp_matrix[0][0];
        n_checks++; if (e !== -24'sd1) begin n_fail++; $display("[TB] FAIL flush_m00: got %0d expected -1", e); end
        e = o_mvp_matrix[2][1];
        n_checks++; if (e !== -24'sd10) begin n_fail++; $display("[TB] FAIL flush_m21: got %0d expected -10", e); end
        e = o_mvp_matrix[3][3];
        n_checks++; if (e !== -24'sd16) begin n_fail++; $display("[TB] FAIL flush_m33: got %0d expected -16", e); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_commit_pop();
        load_words(600, 1, 0, 16, 4'd6);
        load_words(700, 1, 0, 16, 4'd7);
        load_words(800, 1, 0, 15, 4'd8);
        i_wr_valid = 1'b1; i_wr_data = 24'd815; i_wr_model_id = 4'd8; i_read_en = 1'b1;
        tick();
        i_wr_valid = 1'b0; i_read_en = 1'b0;
        n_checks++; if (o_count !== 3'd2 || o_mvp_dv !== 1'b1 || o_model_id !== 4'd6) begin n_fail++; $display("[TB] FAIL cp_same_cycle: got count=%0d dv=%b id=%0d expected 2 1 6", o_count, o_mvp_dv, o_model_id); end
        i_read_en = 1'b1;
        tick();
        n_checks++; if (o_model_id !== 4'd7) begin n_fail++; $display("[TB] FAIL cp_order_a: got %0d expected 7", o_model_id); end
        tick();
        i_read_en = 1'b0;
        n_checks++; if (o_model_id !== 4'd8 || o_mvp_matrix[3][3] !== 24'd815) begin n_fail++; $display("[TB] FAIL cp_order_b: got id=%0d m33=%0d expected 8 815", o_model_id, o_mvp_matrix[3][3]); end
        load_words(1100, 1, 0, 15, 4'd10);
        i_wr_valid = 1'b1; i_wr_data = 24'd1115; i_wr_model_id = 4'd10; i_read_en = 1'b1;
        tick();
        i_wr_valid = 1'b0; i_read_en = 1'b0;
        n_checks++; if (o_underflow !== 1'b1 || o_mvp_dv !== 1'b0 || o_count !== 3'd1) begin n_fail++; $display("[TB] FAIL cp_empty_commit: got uf=%b dv=%b count=%0d expected 1 0 1", o_underflow, o_mvp_dv, o_count); end
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        n_checks++; if (o_mvp_dv !== 1'b1 || o_model_id !== 4'd10 || o_mvp_matrix[0][0] !== 24'd1100) begin n_fail++; $display("[TB] FAIL cp_empty_next: got dv=%b id=%0d m00=%0d expected 1 10 1100", o_mvp_dv, o_model_id, o_mvp_matrix[0][0]); end
    endtask

    task automatic test_reset_wrap();
        load_words(200, 1, 0, 16, 4'd1);
        load_words(300, 1, 0, 16, 4'd2);
        load_words(400, 1, 0, 7, 4'd3);
        reset = 1'b1; i_read_en = 1'b1;
        tick();
        reset = 1'b0; i_read_en = 1'b0;
        n_checks++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_wr_ready !== 1'b1 || o_full !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_flags: got count=%0d empty=%b ready=%b full=%b expected 0 1 1 0", o_count, o_empty, o_wr_ready, o_full); end
        n_checks++; if (o_mvp_dv !== 1'b0 || o_underflow !== 1'b0 || o_model_id !== 4'd0 || o_mvp_matrix !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_outputs: got dv=%b uf=%b id=%0d expected 0 0 0", o_mvp_dv, o_underflow, o_model_id); end
        load_words(0, 1, 0, 2, 4'd0);
        load_words(0, 1, 2, 14, 4'd11);
        n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("[TB] FAIL rst_partial_gone: got %0d expected 1", o_count); end
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        n_checks++; if (o_model_id !== 4'd11 || o_mvp_matrix[0][1] !== 24'd1) begin n_fail++; $display("[TB] FAIL rst_fresh_pop: got id=%0d m01=%0d expected 11 1", o_model_id, o_mvp_matrix[0][1]); end
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 16; i++) begin
                i_wr_valid    = 1'b1;
                i_wr_data     = 24'(1000 * k + i);
                i_wr_model_id = 4'(k);
                i_read_en     = (k >= 2 && i == 0);
                tick();
                if (k >= 2 && i == 0) begin
                    n_checks++; if (o_mvp_dv !== 1'b1 || o_model_id !== 4'(k - 2) || o_mvp_matrix[2][3] !== 24'(1000 * (k - 2) + 11)) begin n_fail++; $display("[TB] FAIL wrap_pop: got dv=%b id=%0d m23=%0d expected 1 %0d %0d", o_mvp_dv, o_model_id, o_mvp_matrix[2][3], k - 2, 1000 * (k - 2) + 11); end
                end
            end
        end
        i_wr_valid = 1'b0;
        i_read_en  = 1'b1;
        for (int k = 8; k < 10; k++) begin
            tick();
            n_checks++; if (o_mvp_dv !== 1'b1 || o_model_id !== 4'(k) || o_mvp_matrix[3][3] !== 24'(1000 * k + 15)) begin n_fail++; $display("[TB] FAIL wrap_tail: got dv=%b id=%0d m33=%0d expected 1 %0d %0d", o_mvp_dv, o_model_id, o_mvp_matrix[3][3], k, 1000 * k + 15); end
        end
        i_read_en = 1'b0;
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 0", o_count); end
    endtask

    // Scenario sequence and final summary.
    initial begin
        reset         = 1'b0;
        i_wr_data     = '0;
        i_wr_model_id = '0;
        i_wr_valid    = 1'b0;
        i_flush       = 1'b0;
        i_read_en     = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_underflow();
        test_flush();
        test_commit_pop();
        test_reset_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
